// File: rtl/rv_gpio_pkg.sv
// Shared GPIO constants for the Nexys board top, the input conditioning stage and the SoC GPIO.
// Also holds a small width helper used to size the prescaler and debounce counters.
package rv_gpio_pkg;

    localparam int GPIO_IN_WIDTH    = 21;
    localparam int DEB_SYNC_STAGES  = 2;
    localparam int DEB_TICK_DIV     = 50000;
    localparam int DEB_STABLE_TICKS = 10;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int clog2Min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rv_debounce_bit.sv
// One debounce channel: synchroniser chain, tick-qualified stability counter,
// accepted level register and registered rise/fall pulses.
module rv_debounce_bit
    import rv_gpio_pkg::*;
#(
    parameter int SYNC_STAGES  = DEB_SYNC_STAGES,
    parameter int STABLE_TICKS = DEB_STABLE_TICKS
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick_i,
    input  logic raw_i,
    output logic data_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int              CntW    = clog2Min1(STABLE_TICKS);
    localparam logic [CntW-1:0] CntLast = CntW'(STABLE_TICKS - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   data_q, data_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   syncLevel;

    assign syncLevel = sync_q[SYNC_STAGES-1];

    // Any cycle where the synchronised pin agrees with the accepted level restarts the count,
    // so only an uninterrupted run of disagreeing ticks can change the output.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};
        cnt_d  = cnt_q;
        data_d = data_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (syncLevel == data_q) begin
            cnt_d = '0;
        end else if (tick_i) begin
            if (cnt_q == CntLast) begin
                data_d = syncLevel;
                cnt_d  = '0;
                rise_d = syncLevel;
                fall_d = ~syncLevel;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            data_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign data_o = data_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/rv_input_debounce.sv
// Board input conditioning: one shared debounce prescaler feeding WIDTH independent
// debounce channels between the raw switch/button pins and the SoC GPIO input.
module rv_input_debounce
    import rv_gpio_pkg::*;
#(
    parameter int WIDTH        = GPIO_IN_WIDTH,
    parameter int SYNC_STAGES  = DEB_SYNC_STAGES,
    parameter int TICK_DIV     = DEB_TICK_DIV,
    parameter int STABLE_TICKS = DEB_STABLE_TICKS
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_raw,
    output logic [WIDTH-1:0] o_data,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall
);

    localparam int                PrescW    = clog2Min1(TICK_DIV);
    localparam logic [PrescW-1:0] PrescLast = PrescW'(TICK_DIV - 1);

    logic [PrescW-1:0] prescCnt_q, prescCnt_d;
    logic              tick;

    // With TICK_DIV of 1 the count sits at zero and tick is asserted every cycle.
    always_comb begin
        tick       = (prescCnt_q == PrescLast);
        prescCnt_d = tick ? '0 : prescCnt_q + PrescW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescCnt_q <= '0;
        end else begin
            prescCnt_q <= prescCnt_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : gChannel
        rv_debounce_bit #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_TICKS (STABLE_TICKS)
        ) u_bit (
            .clk     (clk),
            .reset_n (reset_n),
            .tick_i  (tick),
            .raw_i   (i_raw[i]),
            .data_o  (o_data[i]),
            .rise_o  (o_rise[i]),
            .fall_o  (o_fall[i])
        );
    end

endmodule

// File: tb/tb_rv_input_debounce.sv
// Self-checking bench for rv_input_debounce: a run-length debounce model checked every
// cycle, plus directed scenarios with hand-computed latencies and pulse patterns.
module tb_rv_input_debounce;

    localparam int WIDTH        = 4;
    localparam int SYNC_STAGES  = 2;
    localparam int TICK_DIV     = 4;
    localparam int STABLE_TICKS = 3;

    logic             clk     = 1'b0;
    logic             reset_n = 1'b1;
    logic [WIDTH-1:0] i_raw   = '0;
    logic [WIDTH-1:0] o_data;
    logic [WIDTH-1:0] o_rise;
    logic [WIDTH-1:0] o_fall;

    int checks     = 0;
    int failures   = 0;
    int cmpPrinted = 0;

    always #5 clk = ~clk;

    rv_input_debounce #(
        .WIDTH        (WIDTH),
        .SYNC_STAGES  (SYNC_STAGES),
        .TICK_DIV     (TICK_DIV),
        .STABLE_TICKS (STABLE_TICKS)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .i_raw   (i_raw),
        .o_data  (o_data),
        .o_rise  (o_rise),
        .o_fall  (o_fall)
    );

    // Model: the pin reaches the debouncer SYNC_STAGES edges after it is sampled; a level is
    // accepted once it has disagreed with the output across STABLE_TICKS ticks without a break.
    logic [WIDTH-1:0] mData = '0;
    logic [WIDTH-1:0] mRise = '0;
    logic [WIDTH-1:0] mFall = '0;
    logic [WIDTH-1:0] mSeen;
    logic [WIDTH-1:0] mHist[$];
    int               mRun[WIDTH];
    int               modelCyc = 0;
    bit               mTick;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mData = '0;
            mRise = '0;
            mFall = '0;
            modelCyc = 0;
            mHist.delete();
            for (int s = 0; s < SYNC_STAGES; s++) mHist.push_front('0);
            for (int b = 0; b < WIDTH; b++) mRun[b] = 0;
        end else begin
            mSeen = mHist.pop_back();
            mHist.push_front(i_raw);
            mTick = ((modelCyc % TICK_DIV) == TICK_DIV - 1);
            modelCyc++;
            mRise = '0;
            mFall = '0;
            for (int b = 0; b < WIDTH; b++) begin
                if (mSeen[b] == mData[b]) begin
                    mRun[b] = 0;
                end else if (mTick) begin
                    mRun[b]++;
                    if (mRun[b] == STABLE_TICKS) begin
                        mData[b] = mSeen[b];
                        mRun[b]  = 0;
                        if (mSeen[b]) mRise[b] = 1'b1;
                        else          mFall[b] = 1'b1;
                    end
                end
            end
        end
    end

    // Continuous comparison of every output against the model, away from the clock edge.
    always @(negedge clk) begin
        checks += 3;
        if (o_data !== mData) begin
            failures++;
            if (cmpPrinted < 30) $display("[TB] FAIL cmp_data t=%0t actual=%b expected=%b", $time, o_data, mData);
            cmpPrinted++;
        end
        if (o_rise !== mRise) begin
            failures++;
            if (cmpPrinted < 30) $display("[TB] FAIL cmp_rise t=%0t actual=%b expected=%b", $time, o_rise, mRise);
            cmpPrinted++;
        end
        if (o_fall !== mFall) begin
            failures++;
            if (cmpPrinted < 30) $display("[TB] FAIL cmp_fall t=%0t actual=%b expected=%b", $time, o_fall, mFall);
            cmpPrinted++;
        end
    end

    // Tasks run from posedge+1 to posedge+1; input changes happen at posedge+2.
    task automatic applyStimulus(input logic [WIDTH-1:0] value);
        #1;
        i_raw = value;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic checkRange(input string name, input int actual, input int lo, input int hi);
        checks++;
        if (actual < lo || actual > hi) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d..%0d", name, actual, lo, hi);
        end
    endtask

    // Counts edges from the first one that samples the new input until the masked output matches.
    task automatic waitForData(input logic [WIDTH-1:0] mask, input logic [WIDTH-1:0] want,
                               input int limit, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (((o_data & mask) !== want) && n < limit);
    endtask

    task automatic alignToTick();
        for (int j = 0; j < 2 * TICK_DIV; j++) begin
            @(posedge clk);
            #1;
            if ((modelCyc % TICK_DIV) == 0) break;
        end
    endtask

    int  lat;
    bit  bounceBad;

    initial begin
        // Reset with all pins high.
        i_raw = 4'hF;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_data", 32'(o_data), 32'h0);
        checkOutput("reset_rise", 32'(o_rise), 32'h0);
        checkOutput("reset_fall", 32'(o_fall), 32'h0);
        #1 reset_n = 1'b1;
        waitForData(4'hF, 4'hF, 30, lat);
        checkRange("reset_release_latency", lat, 11, 14);
        checkOutput("reset_release_rise", 32'(o_rise), 32'hF);
        checkOutput("reset_release_fall", 32'(o_fall), 32'h0);
        checkOutput("model_data_after_release", 32'(mData), 32'hF);
        @(posedge clk);
        #1;
        checkOutput("reset_release_rise_once", 32'(o_rise), 32'h0);

        // All pins low again.
        applyStimulus(4'h0);
        waitForData(4'hF, 4'h0, 30, lat);
        checkRange("all_fall_latency", lat, 11, 14);
        checkOutput("all_fall_pulse", 32'(o_fall), 32'hF);

        // Clean step on bit 0.
        repeat (3) @(posedge clk);
        #1;
        applyStimulus(4'b0001);
        waitForData(4'b0001, 4'b0001, 30, lat);
        checkRange("step_latency", lat, 11, 14);
        checkOutput("step_rise", 32'(o_rise), 32'b0001);
        checkOutput("step_fall", 32'(o_fall), 32'b0000);
        checkOutput("step_others", 32'(o_data), 32'b0001);

        // Bit 1 bouncing every 3 cycles never survives a full debounce.
        bounceBad = 1'b0;
        for (int t = 0; t < 40; t++) begin
            #1;
            if (t % 3 == 0) i_raw[1] = ~i_raw[1];
            @(posedge clk);
            #1;
            if (o_data[1] || (o_rise != 0) || (o_fall != 0)) bounceBad = 1'b1;
        end
        #1 i_raw[1] = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk);
            #1;
            if (o_data[1] || (o_rise != 0) || (o_fall != 0)) bounceBad = 1'b1;
        end
        checkOutput("bounce_rejected", 32'(bounceBad), 32'h0);
        checkOutput("bounce_data", 32'(o_data), 32'b0001);

        // Bit 2: high 9 cycles, low 1, then high; latency counts from the final rise.
        alignToTick();
        applyStimulus(4'b0101);
        repeat (9) @(posedge clk);
        #1;
        applyStimulus(4'b0001);
        checkOutput("glitch_not_yet_accepted", 32'(o_data[2]), 32'h0);
        @(posedge clk);
        #1;
        applyStimulus(4'b0101);
        waitForData(4'b0100, 4'b0100, 30, lat);
        checkRange("glitch_restart_latency", lat, 11, 14);
        checkOutput("glitch_rise", 32'(o_rise), 32'b0100);

        // Opposite edges on several bits in the same cycle.
        applyStimulus(4'b0011);
        waitForData(4'hF, 4'b0011, 30, lat);
        checkRange("setup_0011_latency", lat, 11, 14);
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(4'b1100);
        waitForData(4'hF, 4'b1100, 30, lat);
        checkRange("opposite_latency", lat, 11, 14);
        checkOutput("opposite_rise", 32'(o_rise), 32'b1100);
        checkOutput("opposite_fall", 32'(o_fall), 32'b0011);

        // Reset while bit 0 has two ticks of disagreement counted.
        alignToTick();
        applyStimulus(4'b1101);
        repeat (8) @(posedge clk);
        #1;
        checkOutput("mid_run_not_accepted", 32'(o_data), 32'b1100);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("mid_reset_data", 32'(o_data), 32'h0);
        checkOutput("mid_reset_rise", 32'(o_rise), 32'h0);
        checkOutput("mid_reset_fall", 32'(o_fall), 32'h0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        waitForData(4'hF, 4'b1101, 30, lat);
        checkRange("mid_reset_restart_latency", lat, 11, 14);
        checkOutput("mid_reset_rise_after", 32'(o_rise), 32'b1101);

        repeat (4) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
